sobel_pixel_streamer: RTL and testbench

Raster pixel source that feeds `sobel_window_generator`. On a `start` pulse it reads one IMG_W×IMG_H frame from a synchronous-read frame-buffer RAM, in row-major order. It emits the frame as a valid/ready pixel stream with `sof`/`eol` markers, optional horizontal blanking, and a completion pulse. A 2-entry output buffer with read-credit accounting absorbs the RAM's 1-cycle read latency and downstream backpressure without losing or duplicating pixels.

---
 rtl/sobel_pixel_streamer.sv | 175 +++++++++++++++++
 tb/tb_sobel_pixel_streamer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_pixel_streamer.sv
// Raster frame-buffer reader producing a valid/ready pixel stream with sof/eol, blanking and done.
// Optional feature macro: SOBEL_STREAM_CHECKSUM_EN (16-bit per-frame pixel checksum on frame_sum).
`default_nettype none

module sobel_pixel_streamer #(
  parameter int PIX_W   = 8,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int H_BLANK = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                mem_rd_en,
  output logic [$clog2(IMG_W*IMG_H)-1:0]      mem_addr,
  input  logic [PIX_W-1:0]                    mem_rd_data,
  output logic                                pixel_valid,
  input  logic                                pixel_ready,
  output logic [PIX_W-1:0]                    pixel_out,
  output logic                                sof,
  output logic                                eol,
  output logic [15:0]                         frame_sum
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BW   = (H_BLANK > 0) ? $clog2(H_BLANK + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  logic [1:0]       state;
  logic [AW-1:0]    addr_cnt;
  logic             inflight;
  logic [PIX_W-1:0] fifo_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [BW-1:0]    blank_cnt;

  logic       xfer;
  logic       last_xfer;
  logic       col_last;
  logic       row_last;
  logic       addr_last;
  logic       fifo_wr;
  logic [2:0] pending;

  assign col_last  = (col == CW'(IMG_W - 1));
  assign row_last  = (row == RW'(IMG_H - 1));
  assign addr_last = (addr_cnt == AW'(NPIX - 1));

  assign pixel_valid = (count != 2'd0) && (blank_cnt == '0);
  assign xfer        = pixel_valid && pixel_ready;
  assign last_xfer   = xfer && col_last && row_last;
  assign pixel_out   = fifo_mem[rd_ptr];
  assign sof         = pixel_valid && (row == '0) && (col == '0);
  assign eol         = pixel_valid && col_last;

  // Credits: buffered + in-flight, less the entry leaving this cycle, must stay below 2.
  assign pending   = {1'b0, count} + {2'b00, inflight} - {2'b00, xfer};
  assign mem_rd_en = (state == S_STREAM) && (pending < 3'd2);
  assign mem_addr  = addr_cnt;
  assign fifo_wr   = inflight;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      addr_cnt    <= '0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      col         <= '0;
      row         <= '0;
      blank_cnt   <= '0;
      done        <= 1'b0;
    end else begin
      done     <= last_xfer;
      inflight <= mem_rd_en;

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (mem_rd_en) begin
            if (addr_last) begin
              addr_cnt <= '0;
              state    <= S_FLUSH;
            end else begin
              addr_cnt <= addr_cnt + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (last_xfer) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (fifo_wr) begin
        fifo_mem[wr_ptr] <= mem_rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (xfer) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, fifo_wr} - {1'b0, xfer};

      if (xfer) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // The last line of the frame gets no trailing blank.
      if (xfer && col_last && !row_last) begin
        blank_cnt <= BW'(H_BLANK);
      end else if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - 1'b1;
      end
    end
  end

`ifdef SOBEL_STREAM_CHECKSUM_EN
  logic [15:0] acc;
  logic [15:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= 16'd0;
      sum_q <= 16'd0;
    end else begin
      if ((state == S_IDLE) && start) begin
        acc <= 16'd0;
      end else if (xfer) begin
        acc <= acc + 16'(pixel_out);
      end
      if (last_xfer) begin
        sum_q <= acc + 16'(pixel_out);
      end
    end
  end

  assign frame_sum = sum_q;
`else
  assign frame_sum = 16'd0;
`endif

`ifndef SYNTHESIS
  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_wr && !xfer && (count == 2'd2)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_sobel_pixel_streamer.sv
// Directed bench for sobel_pixel_streamer: 4x3 frame, stalls, blanking, mid-frame reset, start handling.
`default_nettype none

module tb_sobel_pixel_streamer;

  localparam int PIX_W = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int AW    = $clog2(IMG_W * IMG_H);
`ifdef SOBEL_STREAM_CHECKSUM_EN
  localparam int EXP_SUM = 66;
`else
  localparam int EXP_SUM = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic pixel_ready = 1'b1;
  logic busy, done, mem_rd_en, pixel_valid, sof, eol;
  logic [AW-1:0] mem_addr;
  logic [PIX_W-1:0] mem_rd_data = '0;
  logic [PIX_W-1:0] pixel_out;
  logic [15:0] frame_sum;

  logic start_b = 1'b0;
  logic ready_b = 1'b1;
  logic busy_b, done_b, mem_rd_en_b, pixel_valid_b, sof_b, eol_b;
  logic [AW-1:0] mem_addr_b;
  logic [PIX_W-1:0] mem_rd_data_b = '0;
  logic [PIX_W-1:0] pixel_out_b;
  logic [15:0] frame_sum_b;

  int checks = 0;
  int failures = 0;
  int pix_q[$];
  bit sof_q[$];
  bit eol_q[$];
  int done_cnt = 0;

  sobel_pixel_streamer #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .H_BLANK(0)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_out(pixel_out),
    .sof(sof), .eol(eol), .frame_sum(frame_sum)
  );

  sobel_pixel_streamer #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .H_BLANK(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b), .mem_rd_data(mem_rd_data_b),
    .pixel_valid(pixel_valid_b), .pixel_ready(ready_b), .pixel_out(pixel_out_b),
    .sof(sof_b), .eol(eol_b), .frame_sum(frame_sum_b)
  );

  always #5 clk = ~clk;

  // Frame buffers hold RAM[i] = i with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 8'(mem_addr);
    if (mem_rd_en_b) mem_rd_data_b <= 8'(mem_addr_b);
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (pixel_valid && pixel_ready) begin
        pix_q.push_back(int'(pixel_out));
        sof_q.push_back(sof);
        eol_q.push_back(eol);
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pixel_ready = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%0b exp=0", mem_rd_en); end
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", pixel_valid); end
    checks++; if ({sof, eol} !== 2'b00) begin failures++; $display("FAIL reset_sof_eol got=%b exp=00", {sof, eol}); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    checks++; if (pixel_out !== '0) begin failures++; $display("FAIL reset_pixel got=%0d exp=0", pixel_out); end
    checks++; if (frame_sum !== 16'd0) begin failures++; $display("FAIL reset_sum got=%0d exp=0", frame_sum); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int d0;
    d0 = done_cnt;
    pixel_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", busy); end
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== '0) begin failures++; $display("FAIL basic_first_read got=%0b/%0d exp=1/0", mem_rd_en, mem_addr); end
    tick();
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("FAIL basic_latency got=%0b exp=0", pixel_valid); end
    tick();
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (pixel_valid !== 1'b1 || int'(pixel_out) != k || sof !== (k == 0) || eol !== (k % 4 == 3)) begin
        failures++;
        $display("FAIL basic_px%0d got=v%0b p%0d s%0b e%0b exp=v1 p%0d s%0b e%0b",
                 k, pixel_valid, pixel_out, sof, eol, k, (k == 0), (k % 4 == 3));
      end
      tick();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_done got=%0b/%0b exp=1/0", done, busy); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%0b exp=0", done); end
    checks++; if (int'(frame_sum) != EXP_SUM) begin failures++; $display("FAIL basic_sum got=%0d exp=%0d", frame_sum, EXP_SUM); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_stall();
    int base, d0, p, iss, xf, mx, prev_pix;
    bit prev_stall, finished;
    base = pix_q.size(); d0 = done_cnt;
    p = 0; iss = 0; xf = 0; mx = 0; prev_pix = 0; prev_stall = 0; finished = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      pixel_ready = (p % 4 == 0) || (p % 4 == 3);
      p++;
      #1;
      if (prev_stall) begin
        checks++;
        if (pixel_valid !== 1'b1 || int'(pixel_out) != prev_pix) begin
          failures++;
          $display("FAIL stall_hold got=v%0b p%0d exp=v1 p%0d", pixel_valid, pixel_out, prev_pix);
        end
      end
      iss += int'(mem_rd_en);
      xf += int'(pixel_valid && pixel_ready);
      if (iss - xf > mx) mx = iss - xf;
      prev_stall = pixel_valid && !pixel_ready;
      prev_pix = int'(pixel_out);
      if (done) finished = 1;
      tick();
    end
    pixel_ready = 1'b1;
    checks++; if (!finished) begin failures++; $display("FAIL stall_timeout got=0 exp=1"); end
    checks++; if (pix_q.size() - base != 12) begin failures++; $display("FAIL stall_count got=%0d exp=12", pix_q.size() - base); end
    for (int k = 0; k < 12 && base + k < pix_q.size(); k++) begin
      checks++;
      if (pix_q[base+k] != k || sof_q[base+k] != (k == 0) || eol_q[base+k] != (k % 4 == 3)) begin
        failures++;
        $display("FAIL stall_px%0d got=p%0d s%0b e%0b exp=p%0d s%0b e%0b",
                 k, pix_q[base+k], sof_q[base+k], eol_q[base+k], k, (k == 0), (k % 4 == 3));
      end
    end
    checks++; if (mx > 2) begin failures++; $display("FAIL stall_outstanding got=%0d exp<=2", mx); end
    checks++; if (iss != 12) begin failures++; $display("FAIL stall_reads got=%0d exp=12", iss); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL stall_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_blank();
    start_b = 1'b1; tick(); start_b = 1'b0;
    tick(); tick();
    for (int c = 0; c < 16; c++) begin
      int seg, pos, px;
      bit ev;
      seg = c / 6; pos = c % 6; ev = (pos < 4); px = seg * 4 + pos;
      checks++;
      if (pixel_valid_b !== ev || (ev && (int'(pixel_out_b) != px || eol_b !== (pos == 3) || sof_b !== (px == 0)))) begin
        failures++;
        $display("FAIL blank_c%0d got=v%0b p%0d e%0b exp=v%0b p%0d e%0b",
                 c, pixel_valid_b, pixel_out_b, eol_b, ev, px, (pos == 3));
      end
      tick();
    end
    checks++; if (done_b !== 1'b1 || busy_b !== 1'b0) begin failures++; $display("FAIL blank_done got=%0b/%0b exp=1/0", done_b, busy_b); end
    tick();
    checks++; if (int'(frame_sum_b) != EXP_SUM) begin failures++; $display("FAIL blank_sum got=%0d exp=%0d", frame_sum_b, EXP_SUM); end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit found;
    d0 = done_cnt; found = 0; pixel_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (pixel_valid === 1'b1 && pixel_out === 8'd5) found = 1;
      else tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL rstmid_reach got=0 exp=1"); end
    rst = 1'b1; tick();
    checks++; if (pixel_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0) begin
      failures++; $display("FAIL rstmid_state got=v%0b b%0b d%0b r%0b exp=0000", pixel_valid, busy, done, mem_rd_en);
    end
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=%0d", done_cnt, d0); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== '0) begin failures++; $display("FAIL rstmid_restart got=%0b/%0d exp=1/0", mem_rd_en, mem_addr); end
    tick(); tick();
    checks++; if (pixel_valid !== 1'b1 || sof !== 1'b1 || pixel_out !== 8'd0) begin
      failures++; $display("FAIL rstmid_sof got=v%0b s%0b p%0d exp=v1 s1 p0", pixel_valid, sof, pixel_out);
    end
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (done === 1'b1) found = 1;
      else tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL rstmid_done_timeout got=0 exp=1"); end
    tick();
  endtask

  task automatic test_start_handling();
    int base, d0, bad;
    bit found;
    base = pix_q.size(); d0 = done_cnt; found = 0; bad = 0;
    pixel_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (done === 1'b1) found = 1;
      else tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL start_done_timeout got=0 exp=1"); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== '0 || busy !== 1'b1) begin
      failures++; $display("FAIL start_in_done got=r%0b a%0d b%0b exp=r1 a0 b1", mem_rd_en, mem_addr, busy);
    end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL start_ignored_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (pix_q.size() - base != 12) begin failures++; $display("FAIL start_ignored_count got=%0d exp=12", pix_q.size() - base); end
    for (int k = 0; k < 12 && base + k < pix_q.size(); k++) begin
      if (pix_q[base+k] != k) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL start_ignored_seq got=%0d_bad exp=0_bad", bad); end
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (done === 1'b1) found = 1;
      else tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL start_second_timeout got=0 exp=1"); end
    bad = 0;
    for (int k = 0; k < 12 && base + 12 + k < pix_q.size(); k++) begin
      if (pix_q[base+12+k] != k) bad++;
    end
    checks++; if (pix_q.size() - base != 24 || bad != 0) begin
      failures++; $display("FAIL start_second_seq got=%0d_px_%0d_bad exp=24_px_0_bad", pix_q.size() - base, bad);
    end
    tick();
    checks++; if (int'(frame_sum) != EXP_SUM) begin failures++; $display("FAIL start_second_sum got=%0d exp=%0d", frame_sum, EXP_SUM); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_blank();
    test_reset_mid();
    test_start_handling();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
